lsu_mem_arbiter: RTL

//  Shares the single-port data memory (0x2000-0x3FFF) between two requesters:
//  m0 = CPU load/store path, m1 = secondary master (DMA / debug loader).

---
 rtl/lsu_arb_pkg.sv | 19 +
 rtl/lsu_mem_arbiter_if.sv | 21 ++
 rtl/lsu_arb_grant.sv | 30 +++
 rtl/lsu_mem_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the LSU data-memory arbiter.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } mst_id_e;

  // Data memory window served by this arbiter.
  localparam logic [31:0] MEM_BASE = 32'h0000_2000;
  localparam logic [31:0] MEM_LAST = 32'h0000_3FFF;

endpackage

// File: rtl/lsu_mem_arbiter_if.sv
// One requester channel into the arbiter: request fields out of the master,
// grant and read return back into it.
interface lsu_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          wren;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    be;
  logic          lock;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, wren, addr, wdata, be, lock,
                  input  gnt, rvalid, rdata);
  modport slave  (input  req, wren, addr, wdata, be, lock,
                  output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_arb_grant.sv
// Combinational grant select: fixed priority to m0, lock ownership, and an
// aged m1 request overriding m0 once while arbitrating freely.
module lsu_arb_grant
  import lsu_arb_pkg::*;
(
  input  arb_state_e i_state,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_aged,
  output logic       o_gnt0,
  output logic       o_gnt1
);

  // Pick at most one winner; a locked owner excludes the other master.
  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    case (i_state)
      ARB: begin
        if (i_aged && i_req1) o_gnt1 = 1'b1;
        else if (i_req0)      o_gnt0 = 1'b1;
        else if (i_req1)      o_gnt1 = 1'b1;
      end
      LOCK0:   o_gnt0 = i_req0;
      LOCK1:   o_gnt1 = i_req1;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Two-master arbiter for the single-port data memory (0x2000-0x3FFF).
// m0 = CPU LSU (priority), m1 = DMA/debug loader. Lock keeps ownership across
// atomic sequences; read data returns one cycle after the granted load.
// Optional m1 aging: define LSU_ARB_AGING_EN.
module lsu_mem_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  lsu_mem_arbiter_if.slave m0,
  lsu_mem_arbiter_if.slave m1,
  output logic          o_mem_req,
  output logic          o_mem_wren,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic [3:0]    o_mem_be,
  input  logic [DW-1:0] i_mem_rdata
);

  arb_state_e    r_state;
  logic          r_rd_vld;
  mst_id_e       r_rd_owner;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_aged;

`ifdef LSU_ARB_AGING_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] r_age_cnt;

  // Count cycles m1 loses free arbitration; saturate, clear when served.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                                                  r_age_cnt <= '0;
    else if (w_gnt1)                                             r_age_cnt <= '0;
    else if (r_state == ARB && m1.req && r_age_cnt != CW'(MAX_WAIT)) r_age_cnt <= r_age_cnt + 1'b1;
  end

  assign w_aged = (r_age_cnt == CW'(MAX_WAIT));
`else
  assign w_aged = 1'b0;
`endif

  lsu_arb_grant u_grant (
    .i_state (r_state),
    .i_req0  (m0.req),
    .i_req1  (m1.req),
    .i_aged  (w_aged),
    .o_gnt0  (w_gnt0),
    .o_gnt1  (w_gnt1)
  );

  assign m0.gnt = w_gnt0;
  assign m1.gnt = w_gnt1;

  // Lock tracking: enter on a granted locked access, leave once the owner
  // presents lock=0, whether it is accessing or idle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ARB;
    end else begin
      case (r_state)
        ARB: begin
          if (w_gnt0 && m0.lock)      r_state <= LOCK0;
          else if (w_gnt1 && m1.lock) r_state <= LOCK1;
        end
        LOCK0:   if (!m0.lock) r_state <= ARB;
        LOCK1:   if (!m1.lock) r_state <= ARB;
        default: r_state <= ARB;
      endcase
    end
  end

  // Remember who issued the load so next cycle's memory data goes to them.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rd_vld   <= 1'b0;
      r_rd_owner <= M0;
    end else begin
      r_rd_vld   <= (w_gnt0 && !m0.wren) || (w_gnt1 && !m1.wren);
      r_rd_owner <= w_gnt1 ? M1 : M0;
    end
  end

  // Hold the last returned word per master so rdata is stable between returns.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_rd_vld) begin
      if (r_rd_owner == M0) r_rdata0 <= i_mem_rdata;
      else                  r_rdata1 <= i_mem_rdata;
    end
  end

  assign m0.rvalid = r_rd_vld && (r_rd_owner == M0);
  assign m1.rvalid = r_rd_vld && (r_rd_owner == M1);
  assign m0.rdata  = m0.rvalid ? i_mem_rdata : r_rdata0;
  assign m1.rdata  = m1.rvalid ? i_mem_rdata : r_rdata1;

  // Steer the winner's fields to memory; quiet bus when nobody is granted.
  always_comb begin
    o_mem_req   = w_gnt0 | w_gnt1;
    o_mem_wren  = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = '0;
    if (w_gnt0) begin
      o_mem_wren  = m0.wren;
      o_mem_addr  = m0.addr;
      o_mem_wdata = m0.wdata;
      o_mem_be    = m0.be;
    end else if (w_gnt1) begin
      o_mem_wren  = m1.wren;
      o_mem_addr  = m1.addr;
      o_mem_wdata = m1.wdata;
      o_mem_be    = m1.be;
    end
  end

endmodule
